// File: rtl/morse_pkg.sv
// Morse front-end constants: FSM state encodings, gap/dash unit multipliers, counter sizing.
// Pure declarations; no logic, no latency, no flow control.
package morse_pkg;

  localparam int LG_UNITS   = 3;
  localparam int WG_UNITS   = 7;
  localparam int DASH_UNITS = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_MARK  = 2'd1;
  localparam state_t ST_SPACE = 2'd2;
  localparam state_t ST_LGAP  = 2'd3;

  // The interval counter must reach the word gap, which is the longest interval timed.
  function automatic int cnt_width(input int unit_cycles);
    return $clog2(WG_UNITS * unit_cycles + 1);
  endfunction

endpackage

// File: rtl/morse_letter_buffer.sv
// Letter assembly plus a one-deep output holding register with a valid/ready handshake.
// Close loads the held letter in the same cycle; a close while the letter is still held and not accepted drops the new letter and pulses overrun.
module morse_letter_buffer
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 6,
  localparam int LW = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sym_vld,
  input  logic                   sym_dat,
  input  logic                   close_vld,
  input  logic                   code_ready,
  output logic [MAX_SYMBOLS-1:0] code,
  output logic [LW-1:0]          len,
  output logic                   code_err,
  output logic                   code_valid,
  output logic                   overrun
);

  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_SYMBOLS);

  logic [MAX_SYMBOLS-1:0] asm_code_q, asm_code_d;
  logic [LW-1:0]          asm_len_q, asm_len_d;
  logic                   asm_err_q, asm_err_d;
  logic [MAX_SYMBOLS-1:0] code_q, code_d;
  logic [LW-1:0]          len_q, len_d;
  logic                   code_err_q, code_err_d;
  logic                   code_valid_q, code_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   accept;

  assign accept = code_valid_q & code_ready;

  always_comb begin
    asm_code_d   = asm_code_q;
    asm_len_d    = asm_len_q;
    asm_err_d    = asm_err_q;
    code_d       = code_q;
    len_d        = len_q;
    code_err_d   = code_err_q;
    code_valid_d = code_valid_q;
    overrun_d    = 1'b0;

    if (accept) begin
      code_valid_d = 1'b0;
    end

    if (sym_vld) begin
      // A full letter keeps its first symbols; extra ones only mark the error.
      if (asm_len_q == LEN_MAX) begin
        asm_err_d = 1'b1;
      end else begin
        for (int i = 0; i < MAX_SYMBOLS; i++) begin
          if (asm_len_q == LW'(i)) begin
            asm_code_d[i] = sym_dat;
          end
        end
        asm_len_d = asm_len_q + LW'(1);
      end
    end

    if (close_vld) begin
      // An accept in the same cycle frees the holding register for the new letter.
      if (!code_valid_q || accept) begin
        code_d       = asm_code_q;
        len_d        = asm_len_q;
        code_err_d   = asm_err_q;
        code_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      asm_code_d = '0;
      asm_len_d  = '0;
      asm_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_code_q   <= '0;
      asm_len_q    <= '0;
      asm_err_q    <= 1'b0;
      code_q       <= '0;
      len_q        <= '0;
      code_err_q   <= 1'b0;
      code_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      asm_code_q   <= asm_code_d;
      asm_len_q    <= asm_len_d;
      asm_err_q    <= asm_err_d;
      code_q       <= code_d;
      len_q        <= len_d;
      code_err_q   <= code_err_d;
      code_valid_q <= code_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign code       = code_q;
  assign len        = len_q;
  assign code_err   = code_err_q;
  assign code_valid = code_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/morse_letter_decoder.sv
// Morse keying front end: times marks/spaces, classifies dots/dashes, detects letter and word gaps.
// All outputs registered, one cycle after the deciding key sample; a held letter blocks the next one (overrun), key is never stalled.
module morse_letter_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES   = 8,
  parameter int GLITCH_CYCLES = 2,
  parameter int MAX_SYMBOLS   = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               key,
  output logic                               dot,
  output logic                               dash,
  output logic                               lg,
  output logic                               wg,
  output logic [MAX_SYMBOLS-1:0]             code,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]   len,
  output logic                               code_err,
  output logic                               code_valid,
  input  logic                               code_ready,
  output logic                               overrun
);

  localparam int CW = cnt_width(UNIT_CYCLES);

  localparam logic [CW-1:0] CNT_MAX    = CW'(WG_UNITS * UNIT_CYCLES);
  localparam logic [CW-1:0] LG_CNT     = CW'(LG_UNITS * UNIT_CYCLES);
  localparam logic [CW-1:0] DASH_CNT   = CW'(DASH_UNITS * UNIT_CYCLES);
  localparam logic [CW-1:0] GLITCH_CNT = CW'(GLITCH_CYCLES);

  state_t        state_q, state_d;
  state_t        src_q, src_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] gap_q, gap_d;
  logic          key_q, key_d;
  logic          dot_q, dot_d;
  logic          dash_q, dash_d;
  logic          lg_q, lg_d;
  logic          wg_q, wg_d;

  logic          sym_vld, sym_dat, close_vld;
  logic          key_edge;
  logic [CW-1:0] cnt_inc;
  logic [CW:0]   gap_sum;
  logic [CW-1:0] cnt_resume;

  assign key_edge = key ^ key_q;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);

  // A discarded mark is folded back into the gap it interrupted, as if the key never rose.
  assign gap_sum    = {1'b0, gap_q} + {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign cnt_resume = (gap_sum >= {1'b0, CNT_MAX}) ? CNT_MAX : gap_sum[CW-1:0];

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    cnt_d     = key_edge ? CW'(1) : cnt_inc;
    gap_d     = gap_q;
    key_d     = key;
    dot_d     = 1'b0;
    dash_d    = 1'b0;
    lg_d      = 1'b0;
    wg_d      = 1'b0;
    sym_vld   = 1'b0;
    sym_dat   = 1'b0;
    close_vld = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key) begin
          state_d = ST_MARK;
          src_d   = ST_IDLE;
          gap_d   = cnt_q;
        end
      end
      ST_MARK: begin
        if (!key) begin
          if (cnt_q < GLITCH_CNT) begin
            state_d = src_q;
            cnt_d   = cnt_resume;
          end else begin
            sym_vld = 1'b1;
            sym_dat = (cnt_q >= DASH_CNT);
            dot_d   = ~sym_dat;
            dash_d  = sym_dat;
            state_d = ST_SPACE;
          end
        end
      end
      ST_SPACE: begin
        if (cnt_q >= LG_CNT) begin
          close_vld = 1'b1;
          lg_d      = 1'b1;
          if (key) begin
            state_d = ST_MARK;
            src_d   = ST_LGAP;
            gap_d   = cnt_q;
          end else begin
            state_d = ST_LGAP;
          end
        end else if (key) begin
          state_d = ST_MARK;
          src_d   = ST_SPACE;
          gap_d   = cnt_q;
        end
      end
      ST_LGAP: begin
        if (cnt_q >= CNT_MAX) begin
          wg_d = 1'b1;
          if (key) begin
            state_d = ST_MARK;
            src_d   = ST_IDLE;
            gap_d   = cnt_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (key) begin
          state_d = ST_MARK;
          src_d   = ST_LGAP;
          gap_d   = cnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      key_q   <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      lg_q    <= 1'b0;
      wg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      key_q   <= key_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      lg_q    <= lg_d;
      wg_q    <= wg_d;
    end
  end

  assign dot  = dot_q;
  assign dash = dash_q;
  assign lg   = lg_q;
  assign wg   = wg_q;

  morse_letter_buffer #(
    .MAX_SYMBOLS(MAX_SYMBOLS)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .sym_vld    (sym_vld),
    .sym_dat    (sym_dat),
    .close_vld  (close_vld),
    .code_ready (code_ready),
    .code       (code),
    .len        (len),
    .code_err   (code_err),
    .code_valid (code_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Directed bench for morse_letter_decoder: expected pulses and letters are queued as keying is driven, then matched as the DUT emits them.
module tb_morse_letter_decoder;

  localparam int U  = 4;
  localparam int G  = 2;
  localparam int M  = 6;
  localparam int LW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key = 1'b0;
  logic          code_ready = 1'b1;
  logic          dot, dash, lg, wg, code_err, code_valid, overrun;
  logic [M-1:0]  code;
  logic [LW-1:0] len;

  morse_letter_decoder #(
    .UNIT_CYCLES(U),
    .GLITCH_CYCLES(G),
    .MAX_SYMBOLS(M)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .dot        (dot),
    .dash       (dash),
    .lg         (lg),
    .wg         (wg),
    .code       (code),
    .len        (len),
    .code_err   (code_err),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int dsh;
  } sym_t;

  sym_t sym_q[$];
  int   lg_q[$];
  int   wg_q[$];
  int   ovr_q[$];
  int   letter_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   t_low = 0;
  int   lg_seen = 0;
  int   wg_seen = 0;
  sym_t s_exp;
  int   e_tmp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_letter(input logic [M-1:0] c, input logic [LW-1:0] l, input logic e);
    return 32'({e, l, c});
  endfunction

  function automatic logic [31:0] outs();
    return 32'({dot, dash, lg, wg, overrun, code_err, code_valid, len, code});
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Key high for n cycles, then released; a real symbol is expected the cycle after release.
  task automatic mark(input int n);
    key = 1'b1;
    tick(n);
    key = 1'b0;
    t_low = cyc;
    if (n >= G) sym_q.push_back('{at: cyc + 1, dsh: (n >= 2 * U) ? 1 : 0});
  endtask

  task automatic glitch();
    key = 1'b1;
    tick(1);
    key = 1'b0;
  endtask

  // Expectations for the letter closed by the gap after the last real mark.
  task automatic exp_close(input logic [M-1:0] c, input logic [LW-1:0] l, input logic e,
                           input bit keep, input bit word);
    lg_q.push_back(t_low + 3 * U + 1);
    if (keep) letter_q.push_back(pack_letter(c, l, e));
    else ovr_q.push_back(t_low + 3 * U + 1);
    if (word) wg_q.push_back(t_low + 7 * U + 1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (dot || dash) begin
        if (sym_q.size() > 0) s_exp = sym_q.pop_front();
        else s_exp = '{at: -1, dsh: -1};
        chk("sym_cycle", cyc, s_exp.at);
        chk("sym_is_dash", {30'b0, dot, dash}, (s_exp.dsh == 1) ? 32'd1 : 32'd2);
      end
      if (lg) begin
        lg_seen++;
        if (lg_q.size() > 0) e_tmp = lg_q.pop_front();
        else e_tmp = -1;
        chk("lg_cycle", cyc, e_tmp);
        chk("lg_code_valid", {31'b0, code_valid}, 1);
      end
      if (wg) begin
        wg_seen++;
        if (wg_q.size() > 0) e_tmp = wg_q.pop_front();
        else e_tmp = -1;
        chk("wg_cycle", cyc, e_tmp);
      end
      if (overrun) begin
        if (ovr_q.size() > 0) e_tmp = ovr_q.pop_front();
        else e_tmp = -1;
        chk("overrun_cycle", cyc, e_tmp);
      end
      if (code_valid && code_ready) begin
        if (letter_q.size() > 0) e_tmp = letter_q.pop_front();
        else e_tmp = -1;
        chk("letter", pack_letter(code, len, code_err), e_tmp);
      end
    end
  end

  initial begin
    reset = 1'b1;
    key = 1'b0;
    code_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key = ~key;
      tick(1);
    end
    key = 1'b0;
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    tick(40);
    chk("idle_gap_pulses", lg_seen + wg_seen, 0);
    chk("idle_outputs", outs(), 0);

    // Letter A: dot, dash
    mark(4);
    tick(4);
    mark(12);
    exp_close(6'b000010, 3'd2, 1'b0, 1'b1, 1'b1);
    tick(40);

    // Dot/dash threshold, longest intra-letter gap, shortest dot, glitch in gap
    mark(7);
    tick(11);
    mark(8);
    tick(4);
    mark(2);
    tick(3);
    glitch();
    exp_close(6'b000010, 3'd3, 1'b0, 1'b1, 1'b1);
    tick(40);

    // Glitch inside the letter gap of a single dot
    mark(4);
    tick(5);
    glitch();
    exp_close(6'b000000, 3'd1, 1'b0, 1'b1, 1'b1);
    tick(40);

    // Seven dots overflow a six-symbol letter
    repeat (6) begin
      mark(4);
      tick(4);
    end
    mark(4);
    exp_close(6'b000000, 3'd6, 1'b1, 1'b1, 1'b1);
    tick(40);

    // Overrun: E held, T dropped
    code_ready = 1'b0;
    mark(4);
    exp_close(6'b000000, 3'd1, 1'b0, 1'b1, 1'b0);
    tick(16);
    mark(12);
    exp_close(6'b000001, 3'd1, 1'b0, 1'b0, 1'b1);
    tick(20);
    chk("held_valid", {31'b0, code_valid}, 1);
    chk("held_letter", pack_letter(code, len, code_err), pack_letter(6'b000000, 3'd1, 1'b0));
    code_ready = 1'b1;
    tick(1);
    chk("valid_falls", {31'b0, code_valid}, 0);
    tick(15);

    // Accept and close in the same cycle
    code_ready = 1'b0;
    mark(4);
    exp_close(6'b000000, 3'd1, 1'b0, 1'b1, 1'b0);
    tick(16);
    mark(12);
    exp_close(6'b000001, 3'd1, 1'b0, 1'b1, 1'b1);
    tick(12);
    code_ready = 1'b1;
    tick(1);
    chk("simul_valid", {31'b0, code_valid}, 1);
    tick(20);

    // Reset while a letter is held
    code_ready = 1'b0;
    mark(4);
    exp_close(6'b000000, 3'd1, 1'b0, 1'b1, 1'b0);
    tick(16);
    key = 1'b1;
    reset = 1'b1;
    tick(1);
    letter_q.delete();
    chk("midreset_outputs", outs(), 0);
    key = 1'b0;
    tick(1);
    reset = 1'b0;
    code_ready = 1'b1;
    tick(40);
    chk("post_reset_outputs", outs(), 0);

    chk("sym_q_drained", sym_q.size(), 0);
    chk("lg_q_drained", lg_q.size(), 0);
    chk("wg_q_drained", wg_q.size(), 0);
    chk("ovr_q_drained", ovr_q.size(), 0);
    chk("letter_q_drained", letter_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/morse_letter_decoder.md
# morse_letter_decoder

Parametrised Morse keying front end. Times key-down (mark) and key-up (space) intervals in clock cycles and classifies each mark as a dot or dash. Detects letter and word gaps, and assembles each letter's symbols into a code/length word. Completed letters are delivered over a valid/ready handshake to the downstream character lookup. It replaces the fixed single-channel dot/dash/gap FSM and adds configurable unit timing, glitch rejection, letter assembly, overflow and overrun reporting.

## Interface
- UNIT_CYCLES, 8, clock cycles per Morse time unit (>= 2)
- GLITCH_CYCLES, 2, marks shorter than this are discarded (< UNIT_CYCLES)
- MAX_SYMBOLS, 6, maximum dots/dashes per letter (1..8)
- clk  in  1  system clock; the single clock
- reset  in  1  synchronous, active-high reset
- key  in  1  debounced, clk-synchronous key level; 1 = tone/key down
- dot  out  1  one-cycle pulse: dot classified
- dash  out  1  one-cycle pulse: dash classified
- lg  out  1  one-cycle pulse: letter gap detected
- wg  out  1  one-cycle pulse: word gap detected
- code  out  MAX_SYMBOLS  letter symbols; bit i = symbol i (first symbol in bit 0), 1 = dash; unused bits 0
- len  out  $clog2(MAX_SYMBOLS+1)  number of valid symbols in code
- code_err  out  1  letter exceeded MAX_SYMBOLS; only the first MAX_SYMBOLS symbols are kept
- code_valid  out  1  code/len/code_err hold a letter
- code_ready  in  1  consumer accepts the letter when code_valid & code_ready
- overrun  out  1  one-cycle pulse: letter completed while code_valid was high; new letter dropped

## Operation
- Cycle counter cnt, width $clog2(7*UNIT_CYCLES+1).
  - Cleared to 1 on every key transition, incremented otherwise.
  - Saturates at 7*UNIT_CYCLES.
- States:
  - IDLE: key low, no symbols pending, no word-gap armed.
  - MARK: key high.
  - SPACE: key low with symbols pending.
  - LGAP: letter closed, waiting for a word gap.
- Transitions:
  - IDLE→MARK on key=1.
  - MARK→SPACE on key=0, with mark length d = cnt.
    - d < GLITCH_CYCLES: discard the mark. Return to SPACE if symbols are pending, LGAP if a word gap is armed, else IDLE. The gap count continues as if the mark never happened.
    - GLITCH_CYCLES <= d < 2*UNIT_CYCLES: dot, append 0.
    - d >= 2*UNIT_CYCLES: dash, append 1.
  - SPACE→MARK on key=1 when gap < 3*UNIT_CYCLES (intra-letter gap).
  - SPACE→LGAP when cnt reaches 3*UNIT_CYCLES: pulse lg and close the letter.
  - LGAP→MARK on key=1 (new letter, word gap disarmed).
  - LGAP→IDLE when cnt reaches 7*UNIT_CYCLES: pulse wg.
- wg fires at most once per gap and never from IDLE. An idle line produces no lg or wg.
- Appending a symbol when len == MAX_SYMBOLS sets an internal error flag. The symbol is dropped and len stays saturated.
- Closing a letter:
  - If code_valid=0: load code, len and code_err into the output register and set code_valid.
  - If code_valid=1: pulse overrun and leave the held letter untouched.
  - In both cases, clear the assembly register and the error flag.
- Handshake:
  - code_valid falls the cycle after code_valid & code_ready.
  - Output fields are stable while code_valid=1.
  - code_ready is ignored while code_valid=0.
- Close and accept in the same cycle: the accept wins first. The outgoing letter is consumed and the new letter is loaded, so code_valid stays 1 with no overrun.

## Timing
- Reset values:
  - State IDLE, cnt 0.
  - dot, dash, lg, wg, overrun = 0.
  - code = 0, len = 0, code_err = 0, code_valid = 0.
- dot/dash pulse in the cycle after the first sampled key=0 that ends the mark.
- lg pulses in the cycle after cnt reaches 3*UNIT_CYCLES. code_valid rises that same cycle.
- wg pulses in the cycle after cnt reaches 7*UNIT_CYCLES.
- All outputs are registered. There are no combinational paths from key or code_ready to any output.
- Reset asserted mid-letter or mid-handshake discards everything. Outputs return to reset values the following cycle.

## Structure
- Shared package morse_pkg:
  - state enum (IDLE, MARK, SPACE, LGAP)
  - gap multipliers LG_UNITS=3, WG_UNITS=7, DASH_UNITS=2
  - a helper that computes the counter width
- Sub-module morse_letter_buffer: assembly shift/len register plus the output holding register, valid/ready and overrun logic.
- The top level holds the FSM and the counter.

## Test plan
All scenarios use UNIT_CYCLES=4, GLITCH_CYCLES=2, MAX_SYMBOLS=6, code_ready=1 unless stated.

- Reset: hold reset for 3 cycles with key toggling → all outputs 0, state IDLE. Releasing reset with key low produces no lg or wg.
- Letter "A": key high 4, low 4, high 12, low 40 → dot, then dash. lg at gap 12 with code=6'b000010, len=2. wg at gap 28.
- Glitch: key high 1 cycle inside a 10-cycle gap → no dot. The gap counter keeps running, lg fires at 12 cycles from the last real mark, and len is unchanged.
- Overflow: 7 dots then a 12-cycle gap → code=0, len=6, code_err=1.
- Overrun: code_ready=0; send "E" then "T" → first letter held (code=0, len=1). overrun pulses at the second lg. Raising code_ready → code_valid falls one cycle later.
- Simultaneous accept: code_ready is asserted exactly in the cycle the next letter closes → new letter loaded, code_valid stays 1, no overrun.
